inventory_bank: RTL and testbench

INVENTORY_BANK -- requirements
Module: inventory_bank

---
 rtl/inventory_bank.sv | 214 +++++++++++++++++++++
 tb/tb_inventory_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inventory_bank.sv
// inventory_bank: per-slot goods counters behind a one-at-a-time request/response handshake.
// IDLE accepts a request, EXEC applies it to at most one slot, RESP holds the answer until consumed.
module inventory_bank #(
  parameter int NUM_SLOTS = 7,
  parameter int CNT_W     = 3,
  parameter int MAX_CNT   = 7,
  localparam int SLOT_W   = $clog2(NUM_SLOTS + 1),
  localparam int TOT_W    = $clog2(NUM_SLOTS * MAX_CNT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [SLOT_W-1:0]          req_slot,
  input  logic [CNT_W-1:0]           req_qty,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_ok,
  output logic [1:0]                 rsp_err,
  output logic [CNT_W-1:0]           rsp_count,
  output logic [NUM_SLOTS*CNT_W-1:0] counts_flat,
  output logic [NUM_SLOTS-1:0]       empty_mask,
  output logic [TOT_W-1:0]           total
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [1:0] OP_QUERY    = 2'b00;
  localparam logic [1:0] OP_RESTOCK  = 2'b01;
  localparam logic [1:0] OP_DISPENSE = 2'b10;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SLOT = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_UNF  = 2'b11;

  localparam logic [CNT_W:0]    MAX_WIDE  = (CNT_W + 1)'(MAX_CNT);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS);

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [CNT_W-1:0]     qty_q, qty_d;
  logic [CNT_W-1:0]     count_q [NUM_SLOTS];
  logic [CNT_W-1:0]     count_d [NUM_SLOTS];
  logic [TOT_W-1:0]     total_q, total_d;
  logic [NUM_SLOTS-1:0] empty_q, empty_d;
  logic                 rspOk_q, rspOk_d;
  logic [1:0]           rspErr_q, rspErr_d;
  logic [CNT_W-1:0]     rspCount_q, rspCount_d;

  logic                 slotValid;
  logic [CNT_W-1:0]     curCount;
  logic [CNT_W-1:0]     newCount;
  logic [CNT_W:0]       sumWide;
  logic                 writeEn;
  logic                 evalOk;
  logic [1:0]           evalErr;
  logic [CNT_W-1:0]     evalCount;

  // Out-of-range slot numbers select nothing, so curCount reads as zero for them.
  always_comb begin
    curCount = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == SLOT_W'(k + 1)) begin
        curCount = count_q[k];
      end
    end
  end

  assign slotValid = (slot_q != '0) && (slot_q <= LAST_SLOT);
  assign sumWide   = {1'b0, curCount} + {1'b0, qty_q};

  // Decide the outcome of the captured request against the current count.
  always_comb begin
    newCount  = curCount;
    writeEn   = 1'b0;
    evalOk    = 1'b0;
    evalErr   = ERR_SLOT;
    evalCount = '0;
    if (slotValid) begin
      case (op_q)
        OP_QUERY: begin
          evalOk    = 1'b1;
          evalErr   = ERR_NONE;
          evalCount = curCount;
        end
        OP_RESTOCK: begin
          if (sumWide > MAX_WIDE) begin
            evalErr   = ERR_OVF;
            evalCount = curCount;
          end else begin
            newCount  = sumWide[CNT_W-1:0];
            writeEn   = 1'b1;
            evalOk    = 1'b1;
            evalErr   = ERR_NONE;
            evalCount = sumWide[CNT_W-1:0];
          end
        end
        OP_DISPENSE: begin
          if (qty_q > curCount) begin
            evalErr   = ERR_UNF;
            evalCount = curCount;
          end else begin
            newCount  = curCount - qty_q;
            writeEn   = 1'b1;
            evalOk    = 1'b1;
            evalErr   = ERR_NONE;
            evalCount = curCount - qty_q;
          end
        end
        default: begin
          newCount  = '0;
          writeEn   = 1'b1;
          evalOk    = 1'b1;
          evalErr   = ERR_NONE;
          evalCount = '0;
        end
      endcase
    end
  end

  // Handshake sequencing; the running total is adjusted by the delta so it moves with the counts.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    slot_d     = slot_q;
    qty_d      = qty_q;
    count_d    = count_q;
    total_d    = total_q;
    rspOk_d    = rspOk_q;
    rspErr_d   = rspErr_q;
    rspCount_d = rspCount_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          slot_d  = req_slot;
          qty_d   = req_qty;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (writeEn) begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == SLOT_W'(k + 1)) begin
              count_d[k] = newCount;
            end
          end
        end
        total_d    = total_q - TOT_W'(curCount) + TOT_W'(newCount);
        rspOk_d    = evalOk;
        rspErr_d   = evalErr;
        rspCount_d = evalCount;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    empty_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      empty_d[k] = (count_d[k] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      slot_q     <= '0;
      qty_q      <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        count_q[k] <= '0;
      end
      total_q    <= '0;
      empty_q    <= '1;
      rspOk_q    <= 1'b0;
      rspErr_q   <= ERR_NONE;
      rspCount_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      slot_q     <= slot_d;
      qty_q      <= qty_d;
      count_q    <= count_d;
      total_q    <= total_d;
      empty_q    <= empty_d;
      rspOk_q    <= rspOk_d;
      rspErr_q   <= rspErr_d;
      rspCount_q <= rspCount_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : gFlat
    assign counts_flat[g*CNT_W +: CNT_W] = count_q[g];
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_ok     = rspOk_q;
  assign rsp_err    = rspErr_q;
  assign rsp_count  = rspCount_q;
  assign empty_mask = empty_q;
  assign total      = total_q;

endmodule

// File: tb/tb_inventory_bank.sv
// Testbench for inventory_bank: directed vector table, corner sequences and randomized traffic
// against an array-based reference model; a second 6-slot instance checks out-of-range slots.
module tb_inventory_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic [1:0]  reqOp;
  logic [2:0]  reqSlot;
  logic [2:0]  reqQty;
  logic        rspReady;

  logic        reqReady, rspValid, rspOk;
  logic [1:0]  rspErr;
  logic [2:0]  rspCount;
  logic [20:0] countsFlat;
  logic [6:0]  emptyMask;
  logic [5:0]  totalO;

  logic        reqReady6, rspValid6, rspOk6;
  logic [1:0]  rspErr6;
  logic [2:0]  rspCount6;
  logic [17:0] countsFlat6;
  logic [5:0]  emptyMask6;
  logic [5:0]  totalO6;

  int nChecks = 0;
  int nBad    = 0;
  int mdl [1:7];

  typedef struct {
    int op; int slot; int qty;
    int ok; int err; int cnt; int tot; int empty;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;

  inventory_bank dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady),
    .req_op(reqOp), .req_slot(reqSlot), .req_qty(reqQty),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_ok(rspOk), .rsp_err(rspErr),
    .rsp_count(rspCount), .counts_flat(countsFlat), .empty_mask(emptyMask), .total(totalO)
  );

  inventory_bank #(.NUM_SLOTS(6)) dut6 (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady6),
    .req_op(reqOp), .req_slot(reqSlot), .req_qty(reqQty),
    .rsp_valid(rspValid6), .rsp_ready(rspReady), .rsp_ok(rspOk6), .rsp_err(rspErr6),
    .rsp_count(rspCount6), .counts_flat(countsFlat6), .empty_mask(emptyMask6), .total(totalO6)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int k = 1; k <= 7; k++) mdl[k] = 0;
  endtask

  // Reference behaviour from the operation rules, applied to 7 slots of capacity 7.
  task automatic modelOp(input int op, input int slot, input int qty,
                         output int ok, output int err, output int cnt);
    ok = 0; err = 1; cnt = 0;
    if (slot >= 1 && slot <= 7) begin
      case (op)
        0: begin ok = 1; err = 0; cnt = mdl[slot]; end
        1: begin
          if (mdl[slot] + qty > 7) begin err = 2; cnt = mdl[slot]; end
          else begin mdl[slot] = mdl[slot] + qty; ok = 1; err = 0; cnt = mdl[slot]; end
        end
        2: begin
          if (qty > mdl[slot]) begin err = 3; cnt = mdl[slot]; end
          else begin mdl[slot] = mdl[slot] - qty; ok = 1; err = 0; cnt = mdl[slot]; end
        end
        default: begin mdl[slot] = 0; ok = 1; err = 0; cnt = 0; end
      endcase
    end
  endtask

  function automatic int expFlat(input int nSlots);
    int v = 0;
    for (int k = 1; k <= nSlots; k++) v = v | (mdl[k] << (3 * (k - 1)));
    return v;
  endfunction

  function automatic int expTotal(input int nSlots);
    int s = 0;
    for (int k = 1; k <= nSlots; k++) s = s + mdl[k];
    return s;
  endfunction

  function automatic int expEmpty(input int nSlots);
    int m = 0;
    for (int k = 1; k <= nSlots; k++) if (mdl[k] == 0) m = m | (1 << (k - 1));
    return m;
  endfunction

  task automatic checkState();
    checkOutput("counts", int'(countsFlat), expFlat(7));
    checkOutput("total", int'(totalO), expTotal(7));
    checkOutput("empty", int'(emptyMask), expEmpty(7));
    checkOutput("counts6", int'(countsFlat6), expFlat(6));
    checkOutput("total6", int'(totalO6), expTotal(6));
  endtask

  // One full transaction; the model must already hold the post-operation counts.
  task automatic applyStimulus(input int op, input int slot, input int qty, input int hold,
                               input int expOk, input int expErr, input int expCnt);
    int n;
    bit bad6;
    bad6 = (slot == 0 || slot == 7);
    @(negedge clk);
    checkOutput("idle_ready", int'(reqReady), 1);
    reqValid = 1'b1;
    reqOp    = 2'(op);
    reqSlot  = 3'(slot);
    reqQty   = 3'(qty);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("exec_ready", int'(reqReady), 0);
    checkOutput("exec_valid", int'(rspValid), 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rspValid && n < 6);
    if (!rspValid) begin
      nChecks++;
      nBad++;
      $display("[TB] FAIL rsp_timeout: rsp_valid got 0, expected 1 within 6 cycles");
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
      return;
    end
    checkOutput("latency", n, 1);
    checkOutput("rsp_ok", int'(rspOk), expOk);
    checkOutput("rsp_err", int'(rspErr), expErr);
    checkOutput("rsp_count", int'(rspCount), expCnt);
    checkOutput("rsp_err6", int'(rspErr6), bad6 ? 1 : expErr);
    checkOutput("rsp_count6", int'(rspCount6), bad6 ? 0 : expCnt);
    for (int i = 0; i < hold; i++) begin
      reqValid = 1'b1;
      reqOp    = 2'b11;
      @(negedge clk);
      checkOutput("hold_valid", int'(rspValid), 1);
      checkOutput("hold_ready", int'(reqReady), 0);
      checkOutput("hold_count", int'(rspCount), expCnt);
      checkOutput("hold_err", int'(rspErr), expErr);
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("back_idle", int'(reqReady), 1);
    checkOutput("valid_low", int'(rspValid), 0);
    checkState();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    reqValid = 1'b0;
    rspReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    resetModel();
  endtask

  initial begin
    int ok, err, cnt, op, slot, qty;
    vecs[0]  = '{1, 3, 5, 1, 0, 5, 5, 7'b1111011};
    vecs[1]  = '{1, 3, 3, 0, 2, 5, 5, 7'b1111011};
    vecs[2]  = '{2, 3, 6, 0, 3, 5, 5, 7'b1111011};
    vecs[3]  = '{2, 3, 5, 1, 0, 0, 0, 7'b1111111};
    vecs[4]  = '{0, 3, 0, 1, 0, 0, 0, 7'b1111111};
    vecs[5]  = '{1, 1, 0, 1, 0, 0, 0, 7'b1111111};
    vecs[6]  = '{2, 2, 0, 1, 0, 0, 0, 7'b1111111};
    vecs[7]  = '{1, 0, 2, 0, 1, 0, 0, 7'b1111111};
    vecs[8]  = '{1, 7, 7, 1, 0, 7, 7, 7'b0111111};
    vecs[9]  = '{3, 7, 0, 1, 0, 0, 0, 7'b1111111};
    vecs[10] = '{2, 1, 1, 0, 3, 0, 0, 7'b1111111};
    vecs[11] = '{0, 0, 4, 0, 1, 0, 0, 7'b1111111};

    reset = 1'b1; reqValid = 1'b0; reqOp = '0; reqSlot = '0; reqQty = '0; rspReady = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_counts", int'(countsFlat), 0);
    checkOutput("rst_total", int'(totalO), 0);
    checkOutput("rst_empty", int'(emptyMask), 7'h7f);
    checkOutput("rst_valid", int'(rspValid), 0);
    checkOutput("rst_ready", int'(reqReady), 1);
    checkOutput("rst_ok", int'(rspOk), 0);
    checkOutput("rst_err", int'(rspErr), 0);
    checkOutput("rst_count", int'(rspCount), 0);

    for (int i = 0; i < 12; i++) begin
      modelOp(vecs[i].op, vecs[i].slot, vecs[i].qty, ok, err, cnt);
      applyStimulus(vecs[i].op, vecs[i].slot, vecs[i].qty, 0, vecs[i].ok, vecs[i].err, vecs[i].cnt);
      checkOutput("vec_total", int'(totalO), vecs[i].tot);
      checkOutput("vec_empty", int'(emptyMask), vecs[i].empty);
    end

    // Consumer stalls for 4 cycles while a clear of the same slot is offered and must be ignored.
    modelOp(1, 2, 3, ok, err, cnt);
    applyStimulus(1, 2, 3, 4, 1, 0, 3);
    checkOutput("hold_slot2", int'(countsFlat[5:3]), 3);

    pulseReset();
    for (int s = 1; s <= 7; s++) begin
      modelOp(1, s, 7, ok, err, cnt);
      applyStimulus(1, s, 7, 0, 1, 0, 7);
    end
    checkOutput("full_total", int'(totalO), 49);
    checkOutput("full_empty", int'(emptyMask), 0);
    modelOp(3, 7, 0, ok, err, cnt);
    applyStimulus(3, 7, 0, 0, 1, 0, 0);
    checkOutput("clear7_total", int'(totalO), 42);
    checkOutput("clear7_empty", int'(emptyMask), 7'b1000000);

    // Reset lands while restock slot 1 qty 4 is in EXEC.
    pulseReset();
    @(negedge clk);
    reqValid = 1'b1; reqOp = 2'b01; reqSlot = 3'd1; reqQty = 3'd4;
    @(negedge clk);
    reqValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("abort_valid", int'(rspValid), 0);
      @(negedge clk);
    end
    checkOutput("abort_slot1", int'(countsFlat[2:0]), 0);
    checkOutput("abort_total", int'(totalO), 0);

    for (int i = 0; i < 60; i++) begin
      op   = int'($urandom_range(0, 3));
      slot = int'($urandom_range(0, 7));
      qty  = int'($urandom_range(0, 7));
      modelOp(op, slot, qty, ok, err, cnt);
      applyStimulus(op, slot, qty, int'($urandom_range(0, 2)), ok, err, cnt);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
